// File: rtl/nibble_zero_strip_serializer.sv
// nibble_zero_strip_serializer
//   Takes a zero-extended WORD_W-bit word and emits it as NIB_W-bit nibbles,
//   least significant nibble first, with valid/ready handshakes on both sides.
//   Macro NZS_STRIP_EN: when defined, redundant all-zero high nibbles are
//   dropped, so an n-nibble value costs n beats. When undefined, every word
//   emits all NIBS beats and the leading-nibble detector is not built.
module nibble_zero_strip_serializer #(
    parameter int  WORD_W = 32,
    parameter int  NIB_W  = 4,
    parameter int  CNT_W  = 16,
    localparam int NIBS   = WORD_W / NIB_W,
    localparam int IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nibble,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  words_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [WORD_W-1:0] shiftReg;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  lastIdx;
    logic [IDX_W-1:0]  lastIdxNext;
    logic [CNT_W-1:0]  wordCount;
    logic              loadWord;
    logic              advance;
    logic              finish;
    logic              atLast;

`ifdef NZS_STRIP_EN
    // Find the highest nonzero nibble of the incoming word (0 for an all-zero word).
    always_comb begin
        lastIdxNext = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (in_word[i*NIB_W +: NIB_W] != '0) begin
                lastIdxNext = IDX_W'(i);
            end
        end
    end
`else
    // Without stripping every word runs through all of its nibbles.
    assign lastIdxNext = IDX_W'(NIBS - 1);
`endif

    assign atLast = (idx == lastIdx);

    // State register.
    // NOTE: clocked blocks use non-blocking (<=) so every register samples the
    // pre-edge values; blocking (=) here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus handshake and beat outputs.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_nibble = '0;
        out_index  = '0;
        out_last   = 1'b0;
        loadWord   = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    loadWord  = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                out_nibble = shiftReg[NIB_W-1:0];
                out_index  = idx;
                out_last   = atLast;
                if (out_ready) begin
                    if (atLast) begin
                        finish    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Word holding register, beat index and completed-word counter.
    // NOTE: the data registers are reset as well as the FSM so a word cut off
    // by reset leaves nothing behind and the outputs start from known zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shiftReg  <= '0;
            idx       <= '0;
            lastIdx   <= '0;
            wordCount <= '0;
        end else begin
            if (loadWord) begin
                shiftReg <= in_word;
                idx      <= '0;
                lastIdx  <= lastIdxNext;
            end else if (advance) begin
                shiftReg <= shiftReg >> NIB_W;
                idx      <= idx + 1'b1;
            end
            if (finish) begin
                wordCount <= wordCount + 1'b1;
            end
        end
    end

    assign words_done = wordCount;

endmodule
